// File: rtl/multicycle_control.sv
// Control FSM for a multicycle MIPS-subset datapath (FETCH/DECODE/EXEC/MEM/WB).
// Define MC_HALT_ON_ILLEGAL_EN to trap unsupported instructions in HALT; otherwise they retire as NOPs.
module multicycle_control (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] pc_src,
    output logic [2:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic [1:0] reg_dst,
    output logic       mem_to_reg,
    output logic       link,
    output logic [2:0] state,
    output logic       halted
);

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_NOR   = 3'd4;
    localparam logic [2:0] OP_SLT   = 3'd5;
    localparam logic [2:0] OP_SHIFT = 3'd6;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] opc_q, opc_d;
    logic [5:0] fn_q, fn_d;

    logic       mem_req_s, mem_we_s, iord_s, ir_write_s, pc_write_s, reg_write_s;
    logic [1:0] pc_src_s, alu_src_b_s, reg_dst_s;
    logic [2:0] alu_op_s;
    logic       mem_to_reg_s, link_s, halted_s;

    function automatic logic is_legal(input logic [5:0] opc, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        case (opc)
            OPC_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR,
                    FN_SLT, FN_SLL, FN_SRL, FN_JR: ok = 1'b1;
                    default:                       ok = 1'b0;
                endcase
            end
            OPC_ADDI, OPC_ANDI, OPC_ORI, OPC_LW, OPC_SW,
            OPC_BEQ, OPC_BNE, OPC_J, OPC_JAL: ok = 1'b1;
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] rtype_alu_op(input logic [5:0] fn);
        logic [2:0] op;
        case (fn)
            FN_ADD:         op = OP_ADD;
            FN_SUB:         op = OP_SUB;
            FN_AND:         op = OP_AND;
            FN_OR:          op = OP_OR;
            FN_NOR:         op = OP_NOR;
            FN_SLT:         op = OP_SLT;
            FN_SLL, FN_SRL: op = OP_SHIFT;
            default:        op = OP_ADD;
        endcase
        return op;
    endfunction

    // State and captured instruction fields
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            opc_q   <= 6'd0;
            fn_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            fn_q    <= fn_d;
        end
    end

    // Next-state and raw control decode
    always_comb begin
        state_d      = state_q;
        opc_d        = opc_q;
        fn_d         = fn_q;
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        iord_s       = 1'b0;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        pc_src_s     = 2'd0;
        alu_op_s     = OP_ADD;
        alu_src_b_s  = 2'd0;
        reg_dst_s    = 2'd0;
        mem_to_reg_s = 1'b0;
        link_s       = 1'b0;
        halted_s     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_s = 1'b1;
                if (mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_d    = S_DECODE;
                end else begin
                    state_d    = S_FETCH;
                end
            end
            S_DECODE: begin
                opc_d = opcode;
                fn_d  = funct;
                if (is_legal(opcode, funct)) begin
                    state_d = S_EXEC;
                end else begin
`ifdef MC_HALT_ON_ILLEGAL_EN
                    state_d = S_HALT;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opc_q)
                    OPC_RTYPE: begin
                        if (fn_q == FN_JR) begin
                            pc_write_s = 1'b1;
                            pc_src_s   = 2'd3;
                        end else begin
                            alu_op_s   = rtype_alu_op(fn_q);
                            state_d    = S_WB;
                        end
                    end
                    OPC_ADDI: begin
                        alu_src_b_s = 2'd1;
                        state_d     = S_WB;
                    end
                    OPC_ANDI: begin
                        alu_op_s    = OP_AND;
                        alu_src_b_s = 2'd2;
                        state_d     = S_WB;
                    end
                    OPC_ORI: begin
                        alu_op_s    = OP_OR;
                        alu_src_b_s = 2'd2;
                        state_d     = S_WB;
                    end
                    OPC_LW, OPC_SW: begin
                        alu_src_b_s = 2'd1;
                        state_d     = S_MEM;
                    end
                    OPC_BEQ, OPC_BNE: begin
                        alu_op_s   = OP_SUB;
                        pc_src_s   = 2'd1;
                        pc_write_s = (opc_q == OPC_BEQ) ? zero : ~zero;
                    end
                    OPC_J: begin
                        pc_write_s = 1'b1;
                        pc_src_s   = 2'd2;
                    end
                    OPC_JAL: begin
                        pc_write_s  = 1'b1;
                        pc_src_s    = 2'd2;
                        reg_write_s = 1'b1;
                        reg_dst_s   = 2'd2;
                        link_s      = 1'b1;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req_s = 1'b1;
                iord_s    = 1'b1;
                mem_we_s  = (opc_q == OPC_SW);
                if (mem_ready) begin
                    state_d = (opc_q == OPC_LW) ? S_WB : S_FETCH;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                reg_write_s  = 1'b1;
                reg_dst_s    = (opc_q == OPC_RTYPE) ? 2'd1 : 2'd0;
                mem_to_reg_s = (opc_q == OPC_LW);
                state_d      = S_FETCH;
            end
`ifdef MC_HALT_ON_ILLEGAL_EN
            S_HALT: begin
                halted_s = 1'b1;
                state_d  = S_HALT;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Reset masks every control output combinationally so a pending request drops at once
    always_comb begin
        if (!reset_n) begin
            {mem_req, mem_we, iord, ir_write, pc_write, reg_write} = 6'd0;
            {pc_src, alu_op, alu_src_b, reg_dst}                   = 9'd0;
            {mem_to_reg, link, halted}                             = 3'd0;
        end else begin
            {mem_req, mem_we, iord, ir_write, pc_write, reg_write} =
                {mem_req_s, mem_we_s, iord_s, ir_write_s, pc_write_s, reg_write_s};
            {pc_src, alu_op, alu_src_b, reg_dst} = {pc_src_s, alu_op_s, alu_src_b_s, reg_dst_s};
            {mem_to_reg, link, halted}           = {mem_to_reg_s, link_s, halted_s};
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: vector table, hand-written corner sequences,
// and randomized instructions checked cycle-by-cycle against a per-instruction step model.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write;
    logic [1:0] pc_src, alu_src_b, reg_dst;
    logic [2:0] alu_op, state;
    logic       mem_to_reg, link, halted;

    int vectors     = 0;
    int miscompares = 0;

    multicycle_control dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .pc_src(pc_src),
        .alu_op(alu_op), .alu_src_b(alu_src_b), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .link(link), .state(state), .halted(halted)
    );

    always #5 clk = ~clk;

    localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_H = 5;
    localparam int K_ALU_R = 0, K_ALU_I = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4;
    localparam int K_J = 5, K_JAL = 6, K_JR = 7, K_ILL = 8;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        z;
        int          flat;
        int          mlat;
        int          exp_cycles;
        logic [11:0] exp_exec;
    } vec_t;

    vec_t tbl[19];

    function automatic logic [11:0] mk(input logic [2:0] ao, input logic [1:0] sb, input logic [1:0] ps,
                                       input logic pcw, input logic rw, input logic [1:0] rd, input logic lk);
        return {ao, sb, ps, pcw, rw, rd, lk};
    endfunction

    function automatic logic [20:0] dut_vec();
        return {state, halted, mem_req, mem_we, iord, ir_write, pc_write, reg_write,
                pc_src, alu_op, alu_src_b, reg_dst, mem_to_reg, link};
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: begin
                if (fn == 6'h08) return K_JR;
                if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02}) return K_ALU_R;
                return K_ILL;
            end
            6'h08, 6'h0C, 6'h0D: return K_ALU_I;
            6'h23:               return K_LOAD;
            6'h2B:               return K_STORE;
            6'h04, 6'h05:        return K_BR;
            6'h02:               return K_J;
            6'h03:               return K_JAL;
            default:             return K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] alu_of_funct(input logic [5:0] fn);
        case (fn)
            6'h20:   return 3'd0;
            6'h22:   return 3'd1;
            6'h24:   return 3'd2;
            6'h25:   return 3'd3;
            6'h27:   return 3'd4;
            6'h2A:   return 3'd5;
            default: return 3'd6;
        endcase
    endfunction

    // Expected outputs for one cycle of a given step of an instruction's life
    function automatic logic [20:0] exp_vec(input int ph, input int kind, input logic [5:0] op,
                                            input logic [5:0] fn, input logic z, input logic rdy);
        logic [2:0] st, ao;
        logic       hl, mr, mw, io, irw, pcw, rw, mtr, lk;
        logic [1:0] ps, sb, rd;
        st = 3'(ph);
        {hl, mr, mw, io, irw, pcw, rw, mtr, lk} = 9'd0;
        {ps, sb, rd} = 6'd0;
        ao = 3'd0;
        case (ph)
            P_F: begin mr = 1'b1; irw = rdy; pcw = rdy; end
            P_M: begin mr = 1'b1; io = 1'b1; mw = (kind == K_STORE); end
            P_W: begin rw = 1'b1; rd = (kind == K_ALU_R) ? 2'd1 : 2'd0; mtr = (kind == K_LOAD); end
            P_H: hl = 1'b1;
            P_E: begin
                case (kind)
                    K_ALU_R: ao = alu_of_funct(fn);
                    K_ALU_I: begin
                        ao = (op == 6'h08) ? 3'd0 : (op == 6'h0C) ? 3'd2 : 3'd3;
                        sb = (op == 6'h08) ? 2'd1 : 2'd2;
                    end
                    K_LOAD, K_STORE: sb = 2'd1;
                    K_BR:  begin ao = 3'd1; ps = 2'd1; pcw = (op == 6'h04) ? z : ~z; end
                    K_J:   begin pcw = 1'b1; ps = 2'd2; end
                    K_JAL: begin pcw = 1'b1; ps = 2'd2; rw = 1'b1; rd = 2'd2; lk = 1'b1; end
                    K_JR:  begin pcw = 1'b1; ps = 2'd3; end
                    default: ;
                endcase
            end
            default: ;
        endcase
        return {st, hl, mr, mw, io, irw, pcw, rw, ps, ao, sb, rd, mtr, lk};
    endfunction

    task automatic check(input string nm, input logic [20:0] exp);
        logic [20:0] act;
        act = dut_vec();
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        mem_ready = 1'($urandom);
        #1 check("rst_async", 21'd0);
        @(negedge clk) check("rst_hold", 21'd0);
        @(posedge clk) #1;
        reset_n = 1'b1;
    endtask

    // Runs one instruction from FETCH; entered and left at posedge+1
    task automatic run_instr(input string nm, input logic [31:0] instr, input logic z, input int flat,
                             input int mlat, input bit rnd, output int cycles, output logic [11:0] exec_seen);
        logic [5:0] op, fn;
        logic       rdy, zz;
        int         kind, lat;
        int         ph[$];
        op = instr[31:26];
        fn = instr[5:0];
        kind = classify(op, fn);
        cycles = 0;
        exec_seen = 12'd0;
        ph.push_back(P_F);
        ph.push_back(P_D);
        case (kind)
            K_ALU_R, K_ALU_I: begin ph.push_back(P_E); ph.push_back(P_W); end
            K_LOAD:  begin ph.push_back(P_E); ph.push_back(P_M); ph.push_back(P_W); end
            K_STORE: begin ph.push_back(P_E); ph.push_back(P_M); end
            K_ILL: begin
`ifdef MC_HALT_ON_ILLEGAL_EN
                ph.push_back(P_H); ph.push_back(P_H); ph.push_back(P_H);
`endif
            end
            default: ph.push_back(P_E);
        endcase
        opcode = op;
        funct  = fn;
        foreach (ph[i]) begin
            lat = (ph[i] == P_F) ? flat : (ph[i] == P_M) ? mlat : 0;
            for (int w = 0; w <= lat; w++) begin
                rdy = (ph[i] == P_F || ph[i] == P_M) ? (w == lat) : 1'($urandom);
                zz  = rnd ? 1'($urandom) : z;
                mem_ready = rdy;
                zero      = zz;
                @(negedge clk);
                check(nm, exp_vec(ph[i], kind, op, fn, zz, rdy));
                if (ph[i] == P_E) exec_seen = {alu_op, alu_src_b, pc_src, pc_write, reg_write, reg_dst, link};
                cycles++;
                @(posedge clk) #1;
                if (ph[i] == P_D) begin
                    opcode = 6'($urandom);
                    funct  = 6'($urandom);
                end
            end
        end
        if (kind == K_ILL) begin
`ifdef MC_HALT_ON_ILLEGAL_EN
            do_reset();
`endif
        end
    endtask

    logic [5:0] legal_ops[10] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [5:0] legal_fns[9]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h08};
    logic [5:0] bad_ops[4]    = '{6'h01, 6'h06, 6'h10, 6'h3F};
    logic [5:0] bad_fns[3]    = '{6'h01, 6'h21, 6'h3F};

    initial begin
        int          cyc;
        logic [11:0] ex;
        logic [5:0]  op, fn;
        logic [19:0] mid;

        tbl[0]  = '{"add",    32'h00004020, 1'b0, 0, 0, 4, mk(3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0)};
        tbl[1]  = '{"sub",    32'h00000022, 1'b0, 2, 0, 6, mk(3'd1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0)};
        tbl[2]  = '{"and",    32'h00000024, 1'b0, 0, 0, 4, mk(3'd2, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0)};
        tbl[3]  = '{"or",     32'h00000025, 1'b0, 0, 0, 4, mk(3'd3, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0)};
        tbl[4]  = '{"nor",    32'h00000027, 1'b0, 0, 0, 4, mk(3'd4, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0)};
        tbl[5]  = '{"slt",    32'h0000002A, 1'b0, 0, 0, 4, mk(3'd5, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0)};
        tbl[6]  = '{"sll",    32'h00000000, 1'b0, 0, 0, 4, mk(3'd6, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0)};
        tbl[7]  = '{"srl",    32'h00000002, 1'b0, 0, 0, 4, mk(3'd6, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0)};
        tbl[8]  = '{"jr",     32'h00000008, 1'b0, 0, 0, 3, mk(3'd0, 2'd0, 2'd3, 1'b1, 1'b0, 2'd0, 1'b0)};
        tbl[9]  = '{"addi",   32'h20000005, 1'b0, 0, 0, 4, mk(3'd0, 2'd1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0)};
        tbl[10] = '{"andi",   32'h30000000, 1'b0, 0, 0, 4, mk(3'd2, 2'd2, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0)};
        tbl[11] = '{"ori",    32'h34000000, 1'b0, 0, 0, 4, mk(3'd3, 2'd2, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0)};
        tbl[12] = '{"lw",     32'h8C000000, 1'b0, 0, 3, 8, mk(3'd0, 2'd1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0)};
        tbl[13] = '{"sw",     32'hAC000000, 1'b0, 0, 0, 4, mk(3'd0, 2'd1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0)};
        tbl[14] = '{"beq_t",  32'h10000000, 1'b1, 0, 0, 3, mk(3'd1, 2'd0, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0)};
        tbl[15] = '{"bne_t",  32'h1520FFFD, 1'b0, 0, 0, 3, mk(3'd1, 2'd0, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0)};
        tbl[16] = '{"bne_nt", 32'h1520FFFD, 1'b1, 0, 0, 3, mk(3'd1, 2'd0, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0)};
        tbl[17] = '{"j",      32'h08000000, 1'b0, 0, 0, 3, mk(3'd0, 2'd0, 2'd2, 1'b1, 1'b0, 2'd0, 1'b0)};
        tbl[18] = '{"jal",    32'h0C000010, 1'b0, 0, 0, 3, mk(3'd0, 2'd0, 2'd2, 1'b1, 1'b1, 2'd2, 1'b1)};

        reset_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) check("reset", 21'd0);
        @(posedge clk) #1;
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            run_instr(tbl[i].name, tbl[i].instr, tbl[i].z, tbl[i].flat, tbl[i].mlat, 1'b0, cyc, ex);
            check_int({tbl[i].name, "_cycles"}, cyc, tbl[i].exp_cycles);
            check_int({tbl[i].name, "_exec"}, int'(ex), int'(tbl[i].exp_exec));
        end

        // sw interrupted by reset while the store is still waiting on memory
        opcode = 6'h2B; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk) check("sw_fetch", exp_vec(P_F, K_STORE, 6'h2B, 6'h00, 1'b0, 1'b1));
        @(posedge clk) #1 mem_ready = 1'b0;
        @(negedge clk) check("sw_decode", exp_vec(P_D, K_STORE, 6'h2B, 6'h00, 1'b0, 1'b0));
        @(posedge clk) #1;
        @(negedge clk) check("sw_exec", exp_vec(P_E, K_STORE, 6'h2B, 6'h00, 1'b0, 1'b0));
        @(posedge clk) #1;
        @(negedge clk) check("sw_mem_wait", exp_vec(P_M, K_STORE, 6'h2B, 6'h00, 1'b0, 1'b0));
        #2 do_reset();
        mem_ready = 1'b0;
        @(negedge clk) check("post_rst_fetch", exp_vec(P_F, K_STORE, 6'h2B, 6'h00, 1'b0, 1'b0));
        @(posedge clk) #1;

        // unsupported opcode 0x3F
        run_instr("illegal_3f", 32'hFC000000, 1'b0, 0, 0, 1'b0, cyc, ex);
`ifdef MC_HALT_ON_ILLEGAL_EN
        check_int("illegal_cycles", cyc, 5);
`else
        check_int("illegal_cycles", cyc, 2);
`endif
        mem_ready = 1'b0;
        @(negedge clk) check("illegal_next_fetch", exp_vec(P_F, K_ILL, 6'h3F, 6'h00, 1'b0, 1'b0));
        @(posedge clk) #1;

        for (int n = 0; n < 200; n++) begin
            mid = 20'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    op = bad_ops[$urandom_range(0, 3)]; fn = 6'($urandom);
                end else begin
                    op = 6'h00; fn = bad_fns[$urandom_range(0, 2)];
                end
            end else begin
                op = legal_ops[$urandom_range(0, 9)];
                fn = (op == 6'h00) ? legal_fns[$urandom_range(0, 8)] : 6'($urandom);
            end
            run_instr("rand", {op, mid, fn}, 1'b0, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, cyc, ex);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 opcode  input  6  instruction[31:26] from the datapath IR.
REQ-005 funct  input  6  instruction[5:0] from the datapath IR.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory completion strobe for the current mem_req.
REQ-008 mem_req  output  1  memory access request; held until mem_ready.
REQ-009 mem_we  output  1  write qualifier for mem_req; 0 means read.
REQ-010 iord  output  1  memory address select: 0=PC, 1=ALU result.
REQ-011 ir_write / pc_write / reg_write  output  1 each  single-cycle load enables.
REQ-012 pc_src  output  2  PC source: 0=PC+4, 1=branch target, 2=jump target26, 3=rs.
REQ-013 alu_op  output  3  team OP_* encoding (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_SHIFT).
REQ-014 alu_src_b  output  2  ALU B select: 0=rt, 1=sign-ext imm16, 2=zero-ext imm16, 3=constant 4.
REQ-015 reg_dst  output  2  write register select: 0=rt, 1=rd, 2=register 31.
REQ-016 mem_to_reg / link  output  1 each  writeback data select: memory data / PC+4.
REQ-017 state  output  3  current state, for debug.
REQ-018 halted  output  1  high while in HALT.

Function
REQ-019 States SHALL be encoded FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to FETCH on the next edge.
REQ-020 FETCH SHALL assert mem_req with iord=0 and mem_we=0 until mem_ready; on that cycle it SHALL pulse ir_write and pc_write with pc_src=0, then go to DECODE.
REQ-021 DECODE SHALL last one cycle and SHALL register opcode and funct; later states SHALL use only the registered copies.
REQ-022 Supported R-type funct values: add 0x20, sub 0x22, and 0x24, or 0x25, nor 0x27, slt 0x2A, sll 0x00, srl 0x02, jr 0x08.
REQ-023 Supported opcodes: addi 0x08, andi 0x0C, ori 0x0D, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, jal 0x03.
REQ-024 EXEC for ALU R-type and immediate instructions SHALL drive the matching alu_op and alu_src_b (addi=1, andi/ori=2), then go to WB.
REQ-025 EXEC for lw/sw SHALL drive alu_op=OP_ADD with alu_src_b=1, then go to MEM.
REQ-026 EXEC for beq/bne SHALL drive alu_op=OP_SUB with alu_src_b=0 and pc_src=1.
REQ-027 For beq/bne, pc_write SHALL pulse only when the branch is taken (beq: zero=1; bne: zero=0); the state then goes to FETCH.
REQ-028 EXEC for j/jal SHALL pulse pc_write with pc_src=2, then go to FETCH.
REQ-029 jal SHALL also pulse reg_write in EXEC with reg_dst=2 and link=1.
REQ-030 EXEC for jr SHALL pulse pc_write with pc_src=3, then go to FETCH.
REQ-031 MEM SHALL assert mem_req with iord=1 (mem_we=1 for sw) until mem_ready; then sw goes to FETCH and lw goes to WB.
REQ-032 WB SHALL pulse reg_write for one cycle, with reg_dst=1 for R-type and 0 otherwise and mem_to_reg=1 for lw only, then go to FETCH.
REQ-033 Latency without memory stalls: R/I ALU = 4 cycles, lw = 5, sw = 4, branch/jump = 3.
REQ-034 mem_ready while mem_req=0 SHALL be ignored.
REQ-035 mem_ready already high on the first cycle of mem_req SHALL complete the access in that cycle.
REQ-036 All outputs not explicitly asserted in a state SHALL be 0.
REQ-037 Outputs SHALL be combinational from state, the registered fields, zero and mem_ready.

Reset
REQ-038 reset_n=0 SHALL immediately force state=FETCH and clear the registered fields to 0.
REQ-039 During reset, every output SHALL be 0 except state=0.
REQ-040 Reset during a pending mem_req SHALL drop mem_req within the same cycle without waiting for mem_ready.
REQ-041 After reset release, the first rising edge SHALL begin FETCH with mem_req=1.

Configuration
REQ-042 With MC_HALT_ON_ILLEGAL_EN defined, an unsupported opcode or funct in DECODE SHALL go to HALT.
REQ-043 HALT SHALL hold halted=1 with all enables 0 until reset.
REQ-044 Without MC_HALT_ON_ILLEGAL_EN, an unsupported instruction SHALL act as a NOP (DECODE->FETCH, no writes) and halted SHALL be tied to 0.

Verification
REQ-045 add $t0,$zero,$zero (0x00004020), mem_ready high in FETCH -> states 0,1,2,4; alu_op=OP_ADD in EXEC; reg_write with reg_dst=1 in cycle 4.
REQ-046 lw with mem_ready delayed 3 cycles in MEM -> mem_req=1, iord=1 held 3 cycles; then WB with mem_to_reg=1; total 8 cycles.
REQ-047 bne $t1,$zero,-3 (0x1520FFFD) -> with zero=0: pc_write=1, pc_src=1 in EXEC; with zero=1: pc_write=0; both return to FETCH.
REQ-048 jal 0x0C000010 -> EXEC pc_write=1, pc_src=2, reg_write=1, reg_dst=2, link=1.
REQ-049 reset_n low mid-MEM for sw -> mem_req and mem_we drop to 0 immediately; state=0; after release, FETCH begins with mem_req=1.
REQ-050 Opcode 0x3F -> halted=1 and state=5 held when MC_HALT_ON_ILLEGAL_EN is defined; otherwise NOP and back to FETCH after DECODE.
